// File: rtl/obi_mc_fifo_bridge_if.sv
// OBI request/response bundle shared by the writer and reader sides of the bridge.
interface obi_mc_fifo_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_mc_fifo_bridge.sv
// Serial-link OBI writer to core OBI reader bridge through NUM_CH address-selected FIFOs,
// with a test-pattern generator that can take over channel TP_CH.
//   state   | meaning
//   S_IDLE  | test mode off, generator parked
//   S_GAP   | counting down idle cycles before a burst
//   S_PUSH  | pushing incrementing pattern words into TP_CH
//   S_DRAIN | burst done, waiting for TP_CH to be read empty
module obi_mc_fifo_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CH     = 4,
  parameter int TP_CH      = 0,
  parameter int TP_BURST   = 2,
  parameter int TP_GAP     = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              testmode_i,
  input  logic [NUM_CH-1:0] flush_i,
  obi_mc_fifo_bridge_if.slave writer,
  obi_mc_fifo_bridge_if.slave reader,
  output logic [NUM_CH-1:0] fifo_empty_o,
  output logic [NUM_CH-1:0] fifo_full_o,
  output logic [NUM_CH-1:0] overflow_o
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(TP_GAP) + 1;
  localparam int BW = $clog2(TP_BURST) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GAP   = 2'd1;
  localparam logic [1:0] S_PUSH  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [DATA_WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [PW:0]           wr_ptr [NUM_CH];
  logic [PW:0]           rd_ptr [NUM_CH];
  logic [NUM_CH-1:0]     full, empty, push, pop, ovf_set;

  logic [1:0]            state_q;
  logic [GW-1:0]         gap_q;
  logic [BW-1:0]         burst_q;
  logic [DATA_WIDTH-1:0] pattern_q;
  logic                  tpg_push;

  logic [CW-1:0]         w_ch, r_ch;
  logic                  w_valid, r_valid, w_is_push, r_is_pop, w_tp;
  logic                  w_full, r_empty, w_push, r_pop;
  logic [DATA_WIDTH-1:0] r_head;
  logic                  w_rvalid_q, r_rvalid_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic                  unused_bits;

  assign w_ch    = writer.addr[2 +: CW];
  assign r_ch    = reader.addr[2 +: CW];
  assign w_valid = int'(w_ch) < NUM_CH;
  assign r_valid = int'(r_ch) < NUM_CH;

  always_comb begin
    w_full  = 1'b0;
    r_empty = 1'b1;
    r_head  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c][PW] != rd_ptr[c][PW]) && (wr_ptr[c][PW-1:0] == rd_ptr[c][PW-1:0]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == CW'(c)) w_full = full[c];
      if (r_ch == CW'(c)) begin
        r_empty = empty[c];
        r_head  = mem[c][rd_ptr[c][PW-1:0]];
      end
    end
  end

  // The generator owns TP_CH outright in test mode, so writer pushes there stall without overflow.
  assign w_tp      = testmode_i && (w_ch == CW'(TP_CH));
  assign w_is_push = writer.we && w_valid;
  assign r_is_pop  = !reader.we && r_valid;
  assign writer.gnt = w_is_push ? (!w_full && !w_tp) : 1'b1;
  assign reader.gnt = r_is_pop ? !r_empty : 1'b1;
  assign w_push    = writer.req && writer.gnt && w_is_push;
  assign r_pop     = reader.req && reader.gnt && r_is_pop;
  assign tpg_push  = testmode_i && (state_q == S_PUSH) && !full[TP_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      push[c]    = (w_push && (w_ch == CW'(c))) || (tpg_push && (c == TP_CH));
      pop[c]     = r_pop && (r_ch == CW'(c));
      ovf_set[c] = writer.req && w_is_push && !w_tp && w_full && (w_ch == CW'(c));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c][PW-1:0]] <= (tpg_push && (c == TP_CH)) ? pattern_q + 1'b1 : writer.wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      overflow_o <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush_i[c]) begin
          wr_ptr[c]     <= '0;
          rd_ptr[c]     <= '0;
          overflow_o[c] <= 1'b0;
        end else begin
          if (push[c])    wr_ptr[c]     <= wr_ptr[c] + 1'b1;
          if (pop[c])     rd_ptr[c]     <= rd_ptr[c] + 1'b1;
          if (ovf_set[c]) overflow_o[c] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_rvalid_q <= 1'b0;
      r_rvalid_q <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      w_rvalid_q <= writer.req && writer.gnt;
      r_rvalid_q <= reader.req && reader.gnt;
      r_rdata_q  <= r_pop ? r_head : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      burst_q   <= '0;
      pattern_q <= '0;
    end else begin
      if (tpg_push) pattern_q <= pattern_q + 1'b1;
      if (!testmode_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_GAP;
            gap_q   <= GW'(TP_GAP - 1);
          end
          S_GAP: begin
            if (gap_q == '0) begin
              state_q <= S_PUSH;
              burst_q <= BW'(TP_BURST - 1);
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
          S_PUSH: begin
            if (tpg_push) begin
              if (burst_q == '0) state_q <= S_DRAIN;
              else               burst_q <= burst_q - 1'b1;
            end
          end
          S_DRAIN: begin
            if (empty[TP_CH]) begin
              state_q <= S_GAP;
              gap_q   <= GW'(TP_GAP - 1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign writer.rvalid = w_rvalid_q;
  assign writer.rdata  = '0;
  assign reader.rvalid = r_rvalid_q;
  assign reader.rdata  = r_rdata_q;
  assign fifo_empty_o  = empty;
  assign fifo_full_o   = full;

  assign unused_bits = ^{writer.be, reader.be, reader.wdata, writer.addr, reader.addr};
endmodule

// File: tb/tb_obi_mc_fifo_bridge.sv
// Directed plus randomized checks of the multi-channel bridge against a queue-based model.
module tb_obi_mc_fifo_bridge;
  localparam int NCH = 4, DEPTH = 8, TPG = 16, TPB = 2;

  logic clk = 1'b0, rst_n = 1'b0, tm = 1'b0, tm3 = 1'b0;
  logic [NCH-1:0] flush = '0, emp, ful, ovf;
  logic [2:0]     flush3 = '0, emp3, ful3, ovf3;

  always #5 clk = ~clk;

  obi_mc_fifo_bridge_if wif(), rif(), wif3(), rif3();

  obi_mc_fifo_bridge dut (
    .clk_i(clk), .rst_ni(rst_n), .testmode_i(tm), .flush_i(flush),
    .writer(wif), .reader(rif),
    .fifo_empty_o(emp), .fifo_full_o(ful), .overflow_o(ovf)
  );

  obi_mc_fifo_bridge #(.NUM_CH(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .testmode_i(tm3), .flush_i(flush3),
    .writer(wif3), .reader(rif3),
    .fifo_empty_o(emp3), .fifo_full_o(ful3), .overflow_o(ovf3)
  );

  logic [31:0]    mq [NCH][$];
  logic [NCH-1:0] movf = '0;
  logic [31:0]    exp_pat = '0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic wr, input logic wwe, input int wch, input logic [31:0] wd,
                       input logic rr, input logic rwe, input int rch,
                       output logic wg, output logic rg, output logic wrv, output logic rrv,
                       output logic [31:0] rd);
    wif.req = wr; wif.we = wwe; wif.addr = 32'(wch) << 2; wif.wdata = wd;
    rif.req = rr; rif.we = rwe; rif.addr = 32'(rch) << 2;
    @(negedge clk);
    wg = wif.gnt;
    rg = rif.gnt;
    @(posedge clk);
    #1;
    wrv = wif.rvalid; rrv = rif.rvalid; rd = rif.rdata;
    wif.req = 1'b0; rif.req = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [NCH-1:0] e_emp, e_ful;
    for (int c = 0; c < NCH; c++) begin
      e_emp[c] = (mq[c].size() == 0);
      e_ful[c] = (mq[c].size() == DEPTH);
    end
    chk({tag, ".empty"}, 32'(emp), 32'(e_emp));
    chk({tag, ".full"},  32'(ful), 32'(e_ful));
    chk({tag, ".ovf"},   32'(ovf), 32'(movf));
  endtask

  // One bus cycle on both ports; expectations come from the queue model before it is updated.
  task automatic op(input string tag, input bit wr, input bit wwe, input int wch, input logic [31:0] wd,
                    input bit rr, input bit rwe, input int rch);
    logic wg, rg, wrv, rrv;
    logic [31:0] rd, exp_rd;
    bit ewg, erg, owned, do_pop;
    owned  = tm && (wch == 0);
    ewg    = wwe ? ((mq[wch].size() < DEPTH) && !owned) : 1'b1;
    erg    = rwe ? 1'b1 : (mq[rch].size() > 0);
    do_pop = rr && !rwe && erg;
    exp_rd = do_pop ? mq[rch][0] : 32'h0;
    drive(wr, wwe, wch, wd, rr, rwe, rch, wg, rg, wrv, rrv, rd);
    chk({tag, ".wgnt"}, 32'(wg), 32'(ewg));
    chk({tag, ".rgnt"}, 32'(rg), 32'(erg));
    chk({tag, ".wrvalid"}, 32'(wrv), 32'(wr && ewg));
    chk({tag, ".rrvalid"}, 32'(rrv), 32'(rr && erg));
    if (rr && erg) chk({tag, ".rdata"}, rd, exp_rd);
    if (wr && wwe && !owned && (mq[wch].size() >= DEPTH)) movf[wch] = 1'b1;
    if (do_pop) void'(mq[rch].pop_front());
    if (wr && wwe && ewg) mq[wch].push_back(wd);
    check_status(tag);
  endtask

  task automatic do_flush(input int ch);
    flush[ch] = 1'b1;
    tick(1);
    flush = '0;
    mq[ch].delete();
    movf[ch] = 1'b0;
  endtask

  task automatic wait_tpg(input string tag);
    int n;
    n = 0;
    while (emp[0] && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n >= TPG + 1 && n <= TPG + 3), 32'd1);
  endtask

  initial begin
    wif.req = 0; wif.we = 0; wif.addr = 0; wif.be = '1; wif.wdata = 0;
    rif.req = 0; rif.we = 0; rif.addr = 0; rif.be = '1; rif.wdata = 32'hDEAD_BEEF;
    wif3.req = 0; wif3.we = 0; wif3.addr = 0; wif3.be = '1; wif3.wdata = 0;
    rif3.req = 0; rif3.we = 0; rif3.addr = 0; rif3.be = '1; rif3.wdata = 0;

    tick(3);
    chk("rst.empty", 32'(emp), 32'hF);
    chk("rst.full", 32'(ful), 32'h0);
    chk("rst.ovf", 32'(ovf), 32'h0);
    chk("rst.wrvalid", 32'(wif.rvalid), 32'h0);
    chk("rst.rrvalid", 32'(rif.rvalid), 32'h0);
    chk("rst.rdata", rif.rdata, 32'h0);
    chk("rst3.empty", 32'(emp3), 32'h7);
    rst_n = 1'b1;
    tick(1);
    for (int c = 0; c < NCH; c++) op($sformatf("rst.rd%0d", c), 0, 0, 0, 0, 1, 0, c);

    op("wr.ch1", 1, 1, 1, 32'hA0, 0, 0, 0);
    op("wr.ch2", 1, 1, 2, 32'hB0, 0, 0, 0);
    op("rd.ch2", 0, 0, 0, 0, 1, 0, 2);
    op("rd.ch1", 0, 0, 0, 0, 1, 0, 1);

    for (int i = 0; i < DEPTH; i++) op("fill0", 1, 1, 0, $urandom, 0, 0, 0);
    op("stall0", 1, 1, 0, 32'hC0DE, 0, 0, 0);
    op("stallpop0", 1, 1, 0, 32'hC0DE, 1, 0, 0);
    op("retry0", 1, 1, 0, 32'hC0DE, 0, 0, 0);
    do_flush(0);
    chk("flush.empty0", 32'(emp[0]), 32'd1);
    chk("flush.ovf0", 32'(ovf[0]), 32'd0);

    for (int i = 0; i < 3; i++)  op("pre3", 1, 1, 3, $urandom, 0, 0, 0);
    for (int i = 0; i < 10; i++) op("pp3", 1, 1, 3, $urandom, 1, 0, 3);
    for (int i = 0; i < 3; i++)  op("post3", 0, 0, 0, 0, 1, 0, 3);

    op("wr.we0", 1, 0, 1, 32'h1234, 0, 0, 0);
    op("rd.we1", 0, 0, 0, 0, 1, 1, 1);

    for (int i = 0; i < 300; i++) begin
      op("rnd", ($urandom_range(0, 9) < 6), ($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom,
         ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) do_flush($urandom_range(0, 3));
    end

    for (int c = 0; c < NCH; c++) do_flush(c);
    tm = 1'b1;
    wait_tpg("tpg.gap1");
    repeat (TPB) begin
      exp_pat++;
      mq[0].push_back(exp_pat);
    end
    tick(40);
    check_status("tpg.hold");
    op("tpg.wr0", 1, 1, 0, 32'h55, 0, 0, 0);
    op("tpg.wr1", 1, 1, 1, 32'h66, 0, 0, 0);
    op("tpg.rd0a", 0, 0, 0, 0, 1, 0, 0);
    op("tpg.rd0b", 0, 0, 0, 0, 1, 0, 0);
    wait_tpg("tpg.gap2");
    tick(5);
    repeat (TPB) begin
      exp_pat++;
      mq[0].push_back(exp_pat);
    end
    op("tpg.rd0c", 0, 0, 0, 0, 1, 0, 0);
    op("tpg.rd0d", 0, 0, 0, 0, 1, 0, 0);
    op("tpg.rd0e", 0, 0, 0, 0, 1, 0, 0);
    tm = 1'b0;
    tick(2);

    wif3.req = 1; wif3.we = 1; wif3.addr = 32'hC; wif3.wdata = 32'h77;
    rif3.req = 1; rif3.we = 0; rif3.addr = 32'hC;
    @(negedge clk);
    chk("inv.wgnt", 32'(wif3.gnt), 32'd1);
    chk("inv.rgnt", 32'(rif3.gnt), 32'd1);
    @(posedge clk);
    #1;
    wif3.req = 0; rif3.req = 0;
    chk("inv.wrvalid", 32'(wif3.rvalid), 32'd1);
    chk("inv.rrvalid", 32'(rif3.rvalid), 32'd1);
    chk("inv.rdata", rif3.rdata, 32'h0);
    chk("inv.empty", 32'(emp3), 32'h7);
    chk("inv.full", 32'(ful3), 32'h0);
    chk("inv.ovf", 32'(ovf3), 32'h0);

    op("mid.wr1", 1, 1, 1, 32'hAB, 0, 0, 0);
    op("mid.wr2", 1, 1, 2, 32'hCD, 0, 0, 0);
    rst_n = 1'b0;
    tick(1);
    chk("midrst.empty", 32'(emp), 32'hF);
    chk("midrst.rrvalid", 32'(rif.rvalid), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) mq[c].delete();
    movf = '0;
    tick(1);
    op("midrst.rd1", 0, 0, 0, 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
